acc_cfg_master: RTL and testbench

ACC_CFG_MASTER -- requirements
Module: acc_cfg_master

---
 rtl/acc_cfg_master.sv | 165 ++++++++++++++++
 tb/tb_acc_cfg_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cfg_master.sv
// acc_cfg_master: loads an accelerator's source, target and control registers over a
// granted register bus, then waits for its interrupt. Optional macro ACC_TIMEOUT_EN adds a wait timeout.
module acc_cfg_master #(
  parameter int unsigned    DW           = 8,
  parameter int unsigned    AW           = 16,
  parameter int unsigned    BAW          = 16,
  parameter logic [BAW-1:0] REG_SRC_BASE = BAW'(16'h0010),
  parameter logic [BAW-1:0] REG_DST_BASE = BAW'(16'h0012),
  parameter logic [BAW-1:0] REG_CTL      = BAW'(16'h0014),
  parameter logic [DW-1:0]  CTL_START    = DW'(8'h80),
  parameter int unsigned    TO_CYCLES    = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [AW-1:0]  cmd_src,
  input  logic [AW-1:0]  cmd_dst,
  output logic           bus_req,
  input  logic           bus_gnt,
  output logic [BAW-1:0] bus_addr,
  output logic [DW-1:0]  bus_wdata,
  output logic           bus_write,
  input  logic           acc_int,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int unsigned   NB   = AW / DW;
  localparam int unsigned   IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  generate
    if ((AW % DW) != 0 || NB == 0 || TO_CYCLES < 2 || TO_CYCLES > 65535) begin : g_param_check
      $error("acc_cfg_master: AW must be a nonzero multiple of DW, TO_CYCLES within 2..65535");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, REQ, WR_SRC, WR_DST, WR_CTL, WAIT_INT, FIN} state_t;

  state_t        state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_dn;

  always_comb idx_dn = idx - IW'(1);

  function automatic logic [DW-1:0] pick(input logic [AW-1:0] w, input logic [IW-1:0] k);
    return w[k*DW +: DW];
  endfunction

`ifdef ACC_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  assign err = 1'b0;
`endif

  // Each write is presented one cycle ahead and only advances on a granted cycle,
  // so a lost grant simply leaves addr/data/write frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      done      <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      idx       <= '0;
`ifdef ACC_TIMEOUT_EN
      err       <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ACC_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            src_q     <= cmd_src;
            dst_q     <= cmd_dst;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_write <= 1'b1;
            bus_addr  <= REG_SRC_BASE + BAW'(LAST);
            bus_wdata <= pick(src_q, LAST);
            idx       <= LAST;
            state     <= WR_SRC;
          end
        end
        WR_SRC: begin
          if (bus_gnt) begin
            if (idx != '0) begin
              idx       <= idx_dn;
              bus_addr  <= REG_SRC_BASE + BAW'(idx_dn);
              bus_wdata <= pick(src_q, idx_dn);
            end else begin
              idx       <= LAST;
              bus_addr  <= REG_DST_BASE + BAW'(LAST);
              bus_wdata <= pick(dst_q, LAST);
              state     <= WR_DST;
            end
          end
        end
        WR_DST: begin
          if (bus_gnt) begin
            if (idx != '0) begin
              idx       <= idx_dn;
              bus_addr  <= REG_DST_BASE + BAW'(idx_dn);
              bus_wdata <= pick(dst_q, idx_dn);
            end else begin
              bus_addr  <= REG_CTL;
              bus_wdata <= CTL_START;
              state     <= WR_CTL;
            end
          end
        end
        WR_CTL: begin
          if (bus_gnt) begin
            bus_write <= 1'b0;
            bus_req   <= 1'b0;
            state     <= WAIT_INT;
`ifdef ACC_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        WAIT_INT: begin
          if (acc_int) begin
            done  <= 1'b1;
            state <= FIN;
          end
`ifdef ACC_TIMEOUT_EN
          else if (to_cnt == 16'(TO_CYCLES - 1)) begin
            err   <= 1'b1;
            state <= FIN;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        FIN: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cfg_master.sv
// Randomized bench for acc_cfg_master: queue-based job model compared every cycle,
// plus literal write sequences, hold, interrupt, reset-abort, AW=24 and timeout cases.
module tb_acc_cfg_master;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned BAW = 16;
  localparam int unsigned NB  = AW / DW;
`ifdef ACC_TIMEOUT_EN
  localparam bit          TO_ON = 1'b1;
  localparam int unsigned TB_TO = 16;
`else
  localparam bit          TO_ON = 1'b0;
  localparam int unsigned TB_TO = 1024;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0]  cmd_src = '0, cmd_dst = '0;
  logic           bus_req, bus_gnt = 1'b0, bus_write;
  logic [BAW-1:0] bus_addr;
  logic [DW-1:0]  bus_wdata;
  logic           acc_int = 1'b0, busy, done, err;

  logic           v24 = 1'b0, ready24, req24, gnt24 = 1'b1, write24, int24 = 1'b0;
  logic           busy24, done24, err24;
  logic [23:0]    s24 = '0, d24 = '0;
  logic [15:0]    addr24;
  logic [7:0]     wdata24;

  acc_cfg_master #(.DW(DW), .AW(AW), .BAW(BAW), .TO_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .acc_int(acc_int), .busy(busy), .done(done), .err(err));

  acc_cfg_master #(.DW(8), .AW(24), .BAW(16), .TO_CYCLES(TB_TO)) dut24 (
    .clk(clk), .rst(rst), .cmd_valid(v24), .cmd_ready(ready24),
    .cmd_src(s24), .cmd_dst(d24), .bus_req(req24), .bus_gnt(gnt24),
    .bus_addr(addr24), .bus_wdata(wdata24), .bus_write(write24),
    .acc_int(int24), .busy(busy24), .done(done24), .err(err24));

  int vectors = 0;
  int miscompares = 0;
  int hold13 = 0;
  logic [23:0] wlog[$];
  logic [23:0] w24log[$];

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endfunction

  // Job model: 0 idle, 1 awaiting grant, 2 writing queue, 3 awaiting interrupt, 4 status pulse
  int          m_ph = 0;
  int          m_wc = 0;
  bit          m_err = 1'b0;
  logic [23:0] m_q[$];

  always @(negedge clk) begin
    if (rst) begin
      m_ph = 0;
      m_q.delete();
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req", bus_req, 1'b0);
      chk("rst_write", bus_write, 1'b0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_wdata", bus_wdata, 0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
    end else begin
      chk("cmd_ready", cmd_ready, m_ph == 0);
      chk("busy", busy, m_ph != 0);
      chk("bus_req", bus_req, m_ph == 1 || m_ph == 2);
      chk("bus_write", bus_write, m_ph == 2);
      chk("done", done, m_ph == 4 && !m_err);
      chk("err", err, m_ph == 4 && m_err);
      if (m_ph == 2) chk("write_addr_data", {bus_addr, bus_wdata}, m_q[0]);
      if (bus_write && bus_gnt) wlog.push_back({bus_addr, bus_wdata});
      if (bus_write && !bus_gnt && bus_addr == 16'h0013) hold13++;
      case (m_ph)
        0: if (cmd_valid) begin
          for (int k = NB - 1; k >= 0; k--) m_q.push_back({16'h0010 + 16'(k), 8'(cmd_src >> (8 * k))});
          for (int k = NB - 1; k >= 0; k--) m_q.push_back({16'h0012 + 16'(k), 8'(cmd_dst >> (8 * k))});
          m_q.push_back({16'h0014, 8'h80});
          m_ph = 1;
        end
        1: if (bus_gnt) m_ph = 2;
        2: if (bus_gnt) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_ph = 3; m_wc = 0; end
        end
        3: if (acc_int) begin m_ph = 4; m_err = 1'b0; end
           else if (TO_ON && m_wc == int'(TB_TO) - 1) begin m_ph = 4; m_err = 1'b1; end
           else m_wc++;
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) if (!rst && write24 && gnt24) w24log.push_back({addr24, wdata24});

  logic [23:0] exp5[5] = '{24'h0011A5, 24'h00105A, 24'h001312, 24'h001234, 24'h001480};
  logic [23:0] exp7[7] = '{24'h0012AB, 24'h0011CD, 24'h0010EF, 24'h001412,
                           24'h001334, 24'h001256, 24'h001480};

  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d);
    @(posedge clk); #1;
    cmd_src = s; cmd_dst = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wint(input string nm);
    int n = 0;
    while (!(busy && !bus_req && !bus_write) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({nm, "_wait_timeout"}, n, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({nm, "_idle_timeout"}, n, 0);
  endtask

  task automatic finish_job(input string nm);
    @(posedge clk); #1 acc_int = 1'b1;
    @(posedge clk); #1 acc_int = 1'b0;
    wait_idle(nm);
  endtask

  task automatic check_five(input string nm);
    chk({nm, "_count"}, wlog.size(), 5);
    for (int i = 0; i < 5; i++) chk(nm, (i < wlog.size()) ? wlog[i] : 24'hxxxxxx, exp5[i]);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous grant: five back-to-back writes
    bus_gnt = 1'b1;
    wlog.delete();
    start_job(16'hA55A, 16'h1234);
    wait_wint("seq_a");
    check_five("seq_a_write");
    finish_job("seq_a");

    // Grant withdrawn for three cycles while (0013,12) is presented
    wlog.delete(); hold13 = 0;
    start_job(16'hA55A, 16'h1234);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus_write && bus_addr == 16'h0013 && n < 3) begin bus_gnt = 1'b0; n++; end
      else bus_gnt = 1'b1;
      if (busy && !bus_req && !bus_write) break;
    end
    bus_gnt = 1'b1;
    wait_wint("seq_b");
    chk("hold_cycles", hold13, 3);
    check_five("seq_b_write");
    finish_job("seq_b");

    // Interrupt glitch during writes is ignored; real one 10 cycles into the wait
    start_job(16'h0F0F, 16'hF00F);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      acc_int = bus_write && bus_addr == 16'h0010;
      if (busy && !bus_req && !bus_write) break;
    end
    acc_int = 1'b0;
    repeat (9) @(posedge clk);
    #1 acc_int = 1'b1;
    @(negedge clk) chk("done_before", done, 1'b0);
    @(posedge clk); #1 acc_int = 1'b0;
    @(negedge clk) chk("done_pulse", done, 1'b1);
    @(negedge clk);
    chk("done_single", done, 1'b0);
    chk("ready_after_done", cmd_ready, 1'b1);

    // Reset during (0012,34): outputs drop at once, next job replays all writes
    start_job(16'hA55A, 16'h1234);
    n = 0;
    while (!(bus_write && bus_addr == 16'h0012) && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) chk("seq_d_find_timeout", n, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_write_drop", bus_write, 1'b0);
    chk("async_req_drop", bus_req, 1'b0);
    chk("async_busy_drop", busy, 1'b0);
    @(negedge clk); #2 rst = 1'b0;
    wlog.delete();
    start_job(16'hA55A, 16'h1234);
    wait_wint("seq_d");
    check_five("seq_d_replay");
    finish_job("seq_d");

    // AW = 24 instance: seven writes, high byte first
    @(posedge clk); #1 s24 = 24'hABCDEF; d24 = 24'h123456; v24 = 1'b1;
    @(posedge clk); #1 v24 = 1'b0;
    n = 0;
    while (!(busy24 && !req24) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("aw24_wait_timeout", n, 0);
    chk("aw24_count", w24log.size(), 7);
    for (int i = 0; i < 7; i++) chk("aw24_write", (i < w24log.size()) ? w24log[i] : 24'hxxxxxx, exp7[i]);
    @(posedge clk); #1 int24 = 1'b1;
    @(posedge clk); #1 int24 = 1'b0;
    n = 0;
    while (!ready24 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("aw24_idle_timeout", n, 0);

`ifdef ACC_TIMEOUT_EN
    // No interrupt: err after TB_TO wait cycles, no done
    start_job(16'h1111, 16'h2222);
    wait_wint("seq_to");
    n = 0;
    for (int c = 0; c < 100 && !err; c++) begin
      if (busy && !bus_req && !bus_write) n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_err", err, 1'b1);
    wait_idle("seq_to");
`endif

    // Randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 399) == 0);
      bus_gnt   = ($urandom_range(0, 3) != 0);
      acc_int   = ($urandom_range(0, 7) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_src   = 16'($urandom);
      cmd_dst   = 16'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0; acc_int = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
